button_step_scheduler: RTL and testbench
========================================

// Module: button_step_scheduler
// PURPOSE
//  Converts raw up/down push-buttons into clean single-cycle step commands for the
//  4-bit up/down display counter. Synchronises and debounces both buttons, and
//  issues one step on press plus auto-repeat steps while a button is held.
//  Arbitrates between the two buttons so the counter never sees both steps at once.
//  Sits between the board pushbuttons and the counter's increment/decrement inputs.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000    stable cycles before debounced level changes (10 ms @ 50 MHz)
//  HOLD_CYCLES      25000000  cycles after first step before auto-repeat begins (0.5 s)
//  REPEAT_CYCLES    5000000   cycles between auto-repeat steps (0.1 s)
// PORTS
//  CLK_50      in   1  50 MHz system clock
//  reset       in   1  synchronous, active-high reset
//  up_btn      in   1  raw up button, active-high, asynchronous, bouncy
//  down_btn    in   1  raw down button, active-high, asynchronous, bouncy
//  up_step     out  1  one-cycle pulse: increment counter
//  down_step   out  1  one-cycle pulse: decrement counter
//  repeating   out  1  high while auto-repeat is active
//  conflict    out  1  high while in LOCK (both buttons debounced-pressed)
// BEHAVIOUR
//  Reset: all outputs 0; sync flops, debounced levels and timers 0; FSM -> IDLE.
//  Sync: each button passes through a 2-flop synchroniser.
//  Debounce: per-button counter counts while sync level != debounced level, and clears
//   when they are equal. On reaching DEBOUNCE_CYCLES the debounced level takes the sync
//   level and the counter clears. Counter width = $clog2(max param)+1.
//  FSM (registered; step outputs registered, asserted the cycle after the transition):
//   IDLE:   up_db rise with down_db=0 -> PRESS_UP, pulse up_step.
//           down_db rise with up_db=0 -> PRESS_DN, pulse down_step.
//           Both debounced high in the same cycle -> LOCK, no step.
//   PRESS_x: timer counts. Own button release -> IDLE.
//           Other button pressed -> LOCK, no step.
//           Timer reaches HOLD_CYCLES -> REPEAT_x, pulse step, timer clears.
//   REPEAT_x: repeating=1. Every REPEAT_CYCLES -> pulse step, timer clears.
//           Release -> IDLE. Other button pressed -> LOCK.
//   LOCK:   conflict=1, no steps. Exit to IDLE only when both debounced levels are 0.
//           A button still held on exit does not step; a fresh rise is required.
//  Invariants: up_step & down_step never both 1. Step pulses are exactly 1 cycle.
//   There are never two steps in adjacent cycles.
//  Latency: raw edge to step = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
//  Bounce shorter than DEBOUNCE_CYCLES produces no step and no state change.
//  Reset mid-hold or mid-repeat: returns to IDLE. A button held through reset
//   deassertion steps once debounced, because the debounced level restarts at 0.
//  Timers saturate and never wrap. Counter range and wrap-around belong to the
//   counter, not to this block.
// TESTING  (sim params: DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5)
//  Reset 3 cycles, buttons low -> all outputs 0, no steps for 50 cycles.
//  up_btn 0->1 held 10 cycles -> single up_step exactly 7 cycles after first sampled
//   high; down_step stays 0.
//  up_btn toggles every 2 cycles for 30 cycles, then stays low -> zero up_step pulses.
//  down_btn held 60 cycles -> down_step at t=7, 27, 32, 37, ... (every 5 cycles).
//   repeating rises at 27 and falls after release debounces.
//  up held, down pressed at cycle 15 -> conflict=1, no further steps.
//   Release down only -> still LOCK. Release both -> IDLE.
//   Press up again -> one up_step.
//  reset asserted during REPEAT_UP -> outputs 0 the next cycle.
//   Button still held -> one up_step 7 cycles after reset deasserts.

Source files
------------

// File: rtl/button_step_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : button_step_scheduler
//  Purpose  : Synchronise/debounce up and down pushbuttons and turn them into
//             arbitrated single-cycle step pulses with hold-to-repeat.
//  Revision : 1.0  initial release
// ============================================================================
module button_step_scheduler #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic CLK_50,
    input  logic reset,
    input  logic up_btn,
    input  logic down_btn,
    output logic up_step,
    output logic down_step,
    output logic repeating,
    output logic conflict
);

    localparam int c_MAX_DH = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int c_MAX    = (c_MAX_DH > REPEAT_CYCLES) ? c_MAX_DH : REPEAT_CYCLES;
    localparam int c_CW     = $clog2(c_MAX) + 1;

    localparam logic [c_CW-1:0] c_DB_LAST   = c_CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CW-1:0] c_HOLD_LAST = c_CW'(HOLD_CYCLES - 1);
    localparam logic [c_CW-1:0] c_REP_LAST  = c_CW'(REPEAT_CYCLES - 1);
    localparam logic [c_CW-1:0] c_SAT       = '1;

    // bit 0 = up, bit 1 = down
    logic [1:0] w_raw;
    logic [1:0] w_db;
    logic [1:0] w_rise;

    assign w_raw = {down_btn, up_btn};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
            logic            r_s1;
            logic            r_s2;
            logic            r_lvl;
            logic [c_CW-1:0] r_cnt;

            always_ff @(posedge CLK_50) begin
                if (reset) begin
                    r_s1  <= 1'b0;
                    r_s2  <= 1'b0;
                    r_lvl <= 1'b0;
                    r_cnt <= '0;
                end else begin
                    r_s1 <= w_raw[gi];
                    r_s2 <= r_s1;
                    // Any agreement restarts the stability window.
                    if (r_s2 == r_lvl) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_DB_LAST) begin
                        r_lvl <= r_s2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_db[gi] = r_lvl;
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRESS_UP  = 3'd1,
        S_PRESS_DN  = 3'd2,
        S_REPEAT_UP = 3'd3,
        S_REPEAT_DN = 3'd4,
        S_LOCK      = 3'd5
    } state_t;

    state_t          r_state;
    logic [c_CW-1:0] r_timer;
    logic [1:0]      r_db_d;
    logic            r_up_step;
    logic            r_down_step;
    logic            r_repeating;
    logic            r_conflict;

    logic            w_up_side;
    logic            w_own;
    logic            w_other;
    logic [c_CW-1:0] w_last;

    assign w_rise    = w_db & ~r_db_d;
    assign w_up_side = (r_state == S_PRESS_UP) || (r_state == S_REPEAT_UP);
    assign w_own     = w_up_side ? w_db[0] : w_db[1];
    assign w_other   = w_up_side ? w_db[1] : w_db[0];
    assign w_last    = ((r_state == S_PRESS_UP) || (r_state == S_PRESS_DN)) ? c_HOLD_LAST : c_REP_LAST;

    always_ff @(posedge CLK_50) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_db_d      <= 2'b00;
            r_up_step   <= 1'b0;
            r_down_step <= 1'b0;
            r_repeating <= 1'b0;
            r_conflict  <= 1'b0;
        end else begin
            r_db_d      <= w_db;
            r_up_step   <= 1'b0;
            r_down_step <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if (w_db[0] && w_db[1]) begin
                        r_state    <= S_LOCK;
                        r_conflict <= 1'b1;
                    end else if (w_rise[0]) begin
                        r_state   <= S_PRESS_UP;
                        r_up_step <= 1'b1;
                    end else if (w_rise[1]) begin
                        r_state     <= S_PRESS_DN;
                        r_down_step <= 1'b1;
                    end
                end
                S_PRESS_UP, S_PRESS_DN, S_REPEAT_UP, S_REPEAT_DN: begin
                    // The opposing press wins over a simultaneous release.
                    if (w_other) begin
                        r_state     <= S_LOCK;
                        r_conflict  <= 1'b1;
                        r_repeating <= 1'b0;
                        r_timer     <= '0;
                    end else if (!w_own) begin
                        r_state     <= S_IDLE;
                        r_repeating <= 1'b0;
                        r_timer     <= '0;
                    end else if (r_timer == w_last) begin
                        r_state     <= w_up_side ? S_REPEAT_UP : S_REPEAT_DN;
                        r_repeating <= 1'b1;
                        r_up_step   <= w_up_side;
                        r_down_step <= ~w_up_side;
                        r_timer     <= '0;
                    end else if (r_timer != c_SAT) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_LOCK: begin
                    r_timer <= '0;
                    if (!w_db[0] && !w_db[1]) begin
                        r_state    <= S_IDLE;
                        r_conflict <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_timer     <= '0;
                    r_repeating <= 1'b0;
                    r_conflict  <= 1'b0;
                end
            endcase
        end
    end

    assign up_step   = r_up_step;
    assign down_step = r_down_step;
    assign repeating = r_repeating;
    assign conflict  = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_button_step_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_step_scheduler
//  Purpose  : Directed bench with an event-level reference model for
//             button_step_scheduler (small debounce/hold/repeat values).
//  Revision : 1.0  initial release
// ============================================================================
module tb_button_step_scheduler;

    localparam int c_DB   = 4;
    localparam int c_HOLD = 20;
    localparam int c_REP  = 5;
    localparam int c_HIST = 8192;

    logic CLK_50 = 1'b0;
    logic reset;
    logic up_btn;
    logic down_btn;
    logic up_step;
    logic down_step;
    logic repeating;
    logic conflict;

    button_step_scheduler #(
        .DEBOUNCE_CYCLES(c_DB),
        .HOLD_CYCLES    (c_HOLD),
        .REPEAT_CYCLES  (c_REP)
    ) u_dut (
        .CLK_50   (CLK_50),
        .reset    (reset),
        .up_btn   (up_btn),
        .down_btn (down_btn),
        .up_step  (up_step),
        .down_step(down_step),
        .repeating(repeating),
        .conflict (conflict)
    );

    always #5 CLK_50 = ~CLK_50;

    int checks = 0;
    int errors = 0;

    // Reference model state: raw samples per edge plus an abstract mode.
    bit hu [0:c_HIST-1];
    bit hd [0:c_HIST-1];
    int edge_n   = 0;
    int last_rst = -100;
    bit db_u = 0, db_d = 0, dbp_u = 0, dbp_d = 0;
    int mode  = 0;   // 0 idle, 1 up held, 2 down held, 3 locked
    int start = 0;   // edge of the press step
    bit e_up = 0, e_dn = 0, e_rep = 0, e_con = 0;

    // Observation log, times relative to the first edge of a scenario
    int t0 = 0;
    int up_q[$];
    int dn_q[$];
    int rep_rise = -1, rep_fall = -1, con_rise = -1;
    bit rep_prev = 0, con_prev = 0;

    // Level seen by the debouncer at edge j is the raw sample two edges back.
    function automatic bit sync_at(input bit sel, input int j);
        if (j - 2 < 0) return 1'b0;
        return sel ? hd[j-2] : hu[j-2];
    endfunction

    // Level flips once the last c_DB post-reset sync samples all disagree with it.
    function automatic bit settle(input bit sel, input bit cur, input int n);
        for (int k = 0; k < c_DB; k++) begin
            if ((n - k) <= last_rst || sync_at(sel, n - k) == cur) return cur;
        end
        return ~cur;
    endfunction

    function automatic bit is_step(input int e);
        return (e == c_HOLD) || (e > c_HOLD && ((e - c_HOLD) % c_REP) == 0);
    endfunction

    initial begin
        forever begin
            @(negedge CLK_50);
            edge_n++;
            if (reset) begin
                hu[edge_n] = 1'b0; hd[edge_n] = 1'b0;
                hu[edge_n-1] = 1'b0; hd[edge_n-1] = 1'b0;
                last_rst = edge_n;
                db_u = 0; db_d = 0; dbp_u = 0; dbp_d = 0;
                mode = 0;
                e_up = 0; e_dn = 0; e_rep = 0; e_con = 0;
            end else begin
                bit nu, nd, ndb_u, ndb_d;
                nu = 0; nd = 0;
                hu[edge_n] = up_btn; hd[edge_n] = down_btn;
                case (mode)
                    0: if (db_u && db_d) mode = 3;
                       else if (db_u && !dbp_u) begin mode = 1; start = edge_n; nu = 1; end
                       else if (db_d && !dbp_d) begin mode = 2; start = edge_n; nd = 1; end
                    1: if (db_d) mode = 3;
                       else if (!db_u) mode = 0;
                       else if (is_step(edge_n - start)) nu = 1;
                    2: if (db_u) mode = 3;
                       else if (!db_d) mode = 0;
                       else if (is_step(edge_n - start)) nd = 1;
                    default: if (!db_u && !db_d) mode = 0;
                endcase
                e_up  = nu;
                e_dn  = nd;
                e_rep = (mode == 1 || mode == 2) && (edge_n - start) >= c_HOLD;
                e_con = (mode == 3);
                ndb_u = settle(1'b0, db_u, edge_n);
                ndb_d = settle(1'b1, db_d, edge_n);
                dbp_u = db_u; dbp_d = db_d;
                db_u  = ndb_u; db_d = ndb_d;
            end

            checks++;
            if ({up_step, down_step, repeating, conflict} !== {e_up, e_dn, e_rep, e_con}) begin
                errors++;
                $display("FAIL outputs edge %0d: got up=%b dn=%b rep=%b con=%b, required up=%b dn=%b rep=%b con=%b",
                         edge_n, up_step, down_step, repeating, conflict, e_up, e_dn, e_rep, e_con);
            end

            if (up_step === 1'b1) up_q.push_back(edge_n + 1 - t0);
            if (down_step === 1'b1) dn_q.push_back(edge_n + 1 - t0);
            if (repeating === 1'b1 && !rep_prev) rep_rise = edge_n + 1 - t0;
            if (repeating === 1'b0 && rep_prev) rep_fall = edge_n + 1 - t0;
            if (conflict === 1'b1 && !con_prev) con_rise = edge_n + 1 - t0;
            rep_prev = (repeating === 1'b1);
            con_prev = (conflict === 1'b1);
        end
    end

    task automatic wait_cyc(input int k);
        repeat (k) @(negedge CLK_50);
        #1;
    endtask

    task automatic start_scn();
        up_q.delete();
        dn_q.delete();
        rep_rise = -1; rep_fall = -1; con_rise = -1;
        t0 = edge_n + 1;
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic chk_q(input string nm, input int act[$], input int exp[$]);
        chk_int({nm, " count"}, act.size(), exp.size());
        if (act.size() == exp.size()) begin
            for (int i = 0; i < exp.size(); i++) chk_int($sformatf("%s[%0d]", nm, i), act[i], exp[i]);
        end
    endtask

    int exp_q[$];

    initial begin
        reset = 1'b1; up_btn = 1'b0; down_btn = 1'b0;
        wait_cyc(3);
        reset = 1'b0;

        // Idle after reset
        start_scn();
        wait_cyc(50);
        chk_int("idle up steps", up_q.size(), 0);
        chk_int("idle down steps", dn_q.size(), 0);

        // Short press: one step at 7
        start_scn();
        up_btn = 1'b1; wait_cyc(10);
        up_btn = 1'b0; wait_cyc(25);
        exp_q = '{7};
        chk_q("press up_q", up_q, exp_q);
        chk_int("press down steps", dn_q.size(), 0);

        // Bounce shorter than the debounce window
        start_scn();
        for (int i = 0; i < 15; i++) begin
            up_btn = (i % 2 == 0);
            wait_cyc(2);
        end
        up_btn = 1'b0; wait_cyc(20);
        chk_int("bounce up steps", up_q.size(), 0);

        // Long hold with auto-repeat
        start_scn();
        down_btn = 1'b1; wait_cyc(60);
        down_btn = 1'b0; wait_cyc(20);
        exp_q = '{7, 27, 32, 37, 42, 47, 52, 57, 62};
        chk_q("hold dn_q", dn_q, exp_q);
        chk_int("hold up steps", up_q.size(), 0);
        chk_int("repeating rise", rep_rise, 27);
        chk_int("repeating fall", rep_fall, 67);

        // Conflict lock and recovery
        start_scn();
        up_btn = 1'b1;   wait_cyc(15);
        down_btn = 1'b1; wait_cyc(25);
        down_btn = 1'b0; wait_cyc(15);
        chk_int("lock held after down release", int'(conflict), 1);
        up_btn = 1'b0;   wait_cyc(25);
        chk_int("lock left after both release", int'(conflict), 0);
        up_btn = 1'b1;   wait_cyc(10);
        up_btn = 1'b0;   wait_cyc(20);
        exp_q = '{7, 87};
        chk_q("lock up_q", up_q, exp_q);
        chk_int("lock down steps", dn_q.size(), 0);
        chk_int("conflict rise", con_rise, 22);

        // Reset during repeat with button still held
        start_scn();
        up_btn = 1'b1; wait_cyc(30);
        reset = 1'b1;  wait_cyc(2);
        reset = 1'b0;  wait_cyc(14);
        up_btn = 1'b0; wait_cyc(20);
        exp_q = '{7, 27, 39};
        chk_q("reset up_q", up_q, exp_q);
        chk_int("reset repeating fall", rep_fall, 31);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
